aes_cipher_iter: RTL and testbench

Iterative AES forward cipher (encryption), the encrypt-direction counterpart of the unrolled inverse cipher.
- Computes one round per clock, so it reuses a single round datapath.
- Consumes the expanded key KExp from the external key-expansion block and the shared SBox table.
- Exposes valid/ready handshakes on both the plaintext input side and the ciphertext output side.

---
 rtl/aes_cipher_iter.sv | 105 ++++++++++
 tb/tb_aes_cipher_iter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption, one round per clock; define AES_CIPHER_ITER_PIPE_EN to overlap output and input handshakes
package aes_const;
  localparam int NB = 4;
  localparam int NR = 10;
endpackage

module aes_cipher_iter
  import aes_const::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  SBox [0:255],
  input  logic [31:0] KExp [0:NB*(NR+1)-1],
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Data_in [0:4*NB-1],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Data_out [0:4*NB-1]
);
  localparam int KW = $clog2(NB*(NR+1));
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  fsm_t fsm, fsm_nx;
  logic [3:0] rc;
  logic [KW-1:0] kbase;
  logic [7:0] st [0:4*NB-1];
  logic [7:0] sr [0:4*NB-1];
  logic [7:0] mc [0:4*NB-1];
  logic [7:0] rnd [0:4*NB-1];
  logic [7:0] ark0 [0:4*NB-1];
  logic accept, last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign accept = in_valid & in_ready;
  assign last = rc == 4'(NR);
  assign kbase = KW'(NB * int'(rc));

  // SubBytes + ShiftRows of the held state, and the initial whitening of a new block
  always_comb begin
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = SBox[st[4*((c+r)%NB)+r]];
        ark0[4*c+r] = Data_in[4*c+r] ^ KExp[c][31-8*r -: 8];
      end
    end
  end

  // MixColumns over GF(2^8) with xtime reduction
  always_comb begin
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        mc[4*c+r] = xt(sr[4*c+r]) ^ xt(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4] ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
      end
    end
  end

  // AddRoundKey for round rc; the final round bypasses MixColumns
  always_comb begin
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        rnd[4*c+r] = (last ? sr[4*c+r] : mc[4*c+r]) ^ KExp[kbase + KW'(c)][31-8*r -: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) fsm <= IDLE;
    else fsm <= fsm_nx;

  // FSM next state; any unused encoding falls back to IDLE
  always_comb fsm_nx = accept ? ROUND : fsm == ROUND ? (last ? DONE : ROUND) : (fsm == DONE && !out_ready) ? DONE : IDLE;

  // handshake outputs decoded from the FSM
  always_comb begin
`ifdef AES_CIPHER_ITER_PIPE_EN
    in_ready = fsm == IDLE || (fsm == DONE && out_ready);
`else
    in_ready = fsm == IDLE;
`endif
    out_valid = fsm == DONE;
  end

  // cipher state, round counter and registered ciphertext
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rc <= '0;
      for (int k = 0; k < 4*NB; k++) begin
        st[k] <= '0;
        Data_out[k] <= '0;
      end
    end else if (accept) begin
      rc <= 4'd1;
      for (int k = 0; k < 4*NB; k++) st[k] <= ark0[k];
    end else if (fsm == ROUND) begin
      rc <= last ? rc : rc + 4'd1;
      for (int k = 0; k < 4*NB; k++) begin
        st[k] <= rnd[k];
        if (last) Data_out[k] <= rnd[k];
      end
    end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: randomized self-checking bench for aes_cipher_iter against a behavioural AES model
module tb_aes_cipher_iter;
  import aes_const::*;
`ifdef AES_CIPHER_ITER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  localparam logic [255:0] FK = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] sb [0:255];
  logic [31:0] kx [0:NB*(NR+1)-1];
  logic [7:0] din [0:4*NB-1];
  logic [7:0] dout [0:4*NB-1];
  logic [127:0] din_flat, dout_flat;
  int n_cmp = 0, n_bad = 0;
  time acc_t = 0;

  aes_cipher_iter dut (
    .clk(clk), .rst(rst), .SBox(sb), .KExp(kx),
    .in_valid(in_valid), .in_ready(in_ready), .Data_in(din),
    .out_valid(out_valid), .out_ready(out_ready), .Data_out(dout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always_comb for (int k = 0; k < 4*NB; k++) din[k] = din_flat[127-8*k -: 8];
  always_comb for (int k = 0; k < 4*NB; k++) dout_flat[127-8*k -: 8] = dout[k];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic gen_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r = 8'h01;
    for (int i = 1; i < j; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic expand(input logic [255:0] key);
    int nk;
    logic [31:0] t;
    nk = NR - 6;
    for (int i = 0; i < NB*(NR+1); i++) begin
      if (i < nk) kx[i] = key[255-32*i -: 32];
      else begin
        t = kx[i-1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
        else if (nk > 6 && i % nk == 4) t = subw(t);
        kx[i] = kx[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ kx[c][31-8*r -: 8];
    for (int rd = 1; rd <= NR; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = (rd < NR) ? gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c] : t[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] ^= kx[4*rd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: a block accepted at one edge shows up NR edges later and stays until taken
  bit inflight = 0, exp_ov = 0, exp_ir;
  int since = 0;
  logic [127:0] exp_do = 0, ct_q = 0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_data_out", dout_flat, 0);
      inflight = 0;
      exp_ov = 0;
      exp_do = 0;
    end else begin
      exp_ir = !inflight && (!exp_ov || (PIPE && out_ready));
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      chk("data_out", dout_flat, exp_do);
      if (exp_ov && out_ready) exp_ov = 0;
      if (inflight) begin
        since++;
        if (since == NR) begin
          exp_ov = 1;
          exp_do = ct_q;
          inflight = 0;
        end
      end
      if (in_valid && exp_ir) begin
        inflight = 1;
        since = 0;
        ct_q = model_enc(din_flat);
      end
    end
  end

  task automatic send(input logic [127:0] pt, input bit keep);
    bit ok = 0;
    din_flat = pt;
    in_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) acc_t = $time;
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!keep) in_valid = 0;
  endtask

  task automatic recv(input int hold, input bit busy, output int lat, output logic [127:0] ct);
    bit seen = 0;
    lat = -1;
    ct = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
      if (seen) begin
        lat = int'(($time - acc_t) / 10);
        ct = dout_flat;
      end else if (busy) begin
        @(posedge clk);
        #1;
        din_flat = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!seen) begin
      chk("output_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_data_out", dout_flat, ct);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, g;
    logic [127:0] ct, pt;
    time t1, t2;
    bit prev;
    rst = 0;
    in_valid = 0;
    out_ready = 0;
    din_flat = 0;
    gen_sbox();
    expand(FK);
    chk("sbox_00", sb[0], 8'h63);
    chk("sbox_53", sb[8'h53], 8'hed);
    chk("model_fips", model_enc(FP), FC);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1 chk("in_ready_after_reset", in_ready, 1);
    send(FP, 0);
    recv(20, 0, lat, ct);
    chk("fips_ct", ct, FC);
    chk("fips_latency", lat, NR);
    expand(256'h0);
    send(128'h0, 0);
    recv(0, 0, lat, ct);
    chk("zero_ct", ct, ZC);
    expand(FK);
    send(FP, 1);
    recv(2, 1, lat, ct);
    chk("busy_ct", ct, FC);
    chk("busy_latency", lat, NR);
    send(FP, 0);
    repeat (4) @(posedge clk);
    #1 rst = 0;
    #1 chk("abort_out_valid", out_valid, 0);
    chk("abort_data_out", dout_flat, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    send(FP, 0);
    recv(0, 0, lat, ct);
    chk("post_abort_ct", ct, FC);
    chk("post_abort_latency", lat, NR);
    for (int n = 0; n < 8; n++) begin
      expand({$urandom, $urandom, $urandom, $urandom, 128'h0});
      pt = {$urandom, $urandom, $urandom, $urandom};
      g = int'($urandom_range(0, 3));
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      send(pt, 0);
      recv(int'($urandom_range(0, 3)), 0, lat, ct);
      chk("rand_ct", ct, model_enc(pt));
      chk("rand_latency", lat, NR);
    end
    expand(FK);
    din_flat = FP;
    in_valid = 1;
    out_ready = 1;
    t1 = 0;
    t2 = 0;
    prev = 0;
    for (int i = 0; i < 60 && t2 == 0; i++) begin
      @(negedge clk);
      if (out_valid && !prev) begin
        if (t1 == 0) t1 = $time;
        else t2 = $time;
      end
      prev = out_valid;
    end
    chk("b2b_second_seen", t2 != 0, 1);
    chk("b2b_gap", 128'((t2 - t1) / 10), PIPE ? 11 : 12);
    @(posedge clk);
    #1 in_valid = 0;
    repeat (2*NR + 6) @(posedge clk);
    #1 out_ready = 0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
